timer_control: RTL and testbench
================================

Name: timer_control

Overview:
- Control stage that sits directly upstream of the cascaded BCD down-counting digit chain (mm:ss) in the egg timer.
- Generates the one-per-second count enable from the system clock.
- Sequences start / pause / stop / alarm from debounced buttons.
- Consumes the chain's all-zero indication and issues the chain clear pulse and the alarm output.

Parameters:
- TICK_DIV, 1000000, clk cycles per count tick (1 s at 1 MHz clk).
- DIV_WIDTH, 20, prescaler width; must satisfy 2^DIV_WIDTH >= TICK_DIV.
- ALARM_TICKS, 10, ticks the alarm stays asserted before auto-return to IDLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  debounced, synchronous level; rising edge = start/resume.
- stop_btn  in  1  debounced, synchronous level; rising edge = pause/stop/acknowledge.
- all_zero  in  1  AND of all digit term_count outputs; high when the display reads 00:00.
- count_en  out  1  one-cycle pulse to enable of least-significant digit counter.
- chain_clear  out  1  registered one-cycle pulse driving digit-chain reset (presets digits).
- alarm  out  1  high while in ALARM.
- state  out  2  encoded FSM state for display/debug.

Behaviour:
- Shared-package state encoding: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- Reset values: state=IDLE, prescaler=0, alarm count=0, count_en=0, chain_clear=0, alarm=0, button-history registers=1 (a button held through reset is not a press).
- Edge detect: press = btn & ~btn_q, registered history. Press is acted on in the cycle it is detected.
- All outputs are registered. chain_clear must never glitch because it feeds an asynchronous reset.
- IDLE:
  - prescaler held at 0.
  - start press -> RUN.
  - stop press ignored.
- RUN:
  - prescaler increments each cycle; at TICK_DIV-1 it wraps to 0.
  - At the wrap cycle:
    - all_zero=0 -> count_en=1 in the next cycle, exactly one cycle wide.
    - all_zero=1 -> no count_en; go to ALARM.
  - stop press -> PAUSE; prescaler value held.
- PAUSE:
  - prescaler and digits frozen.
  - start press -> RUN; prescaler resumes from held value.
  - stop press -> IDLE with chain_clear pulse.
- ALARM:
  - alarm=1.
  - alarm counter increments on each prescaler wrap.
  - At ALARM_TICKS wraps -> IDLE with chain_clear pulse.
  - Any press (start or stop) -> IDLE with chain_clear pulse.
- Simultaneous start and stop press: stop wins in every state.
- Simultaneous stop press and prescaler wrap in RUN: stop wins; no count_en is issued and the prescaler holds at TICK_DIV-1.
- chain_clear is asserted in the cycle after the transition into IDLE and is exactly 1 cycle wide.
- alarm deasserts in the same cycle state reads IDLE.
- The digits themselves are not preset on IDLE entry from reset; the global reset already presets the chain.
- count_en never asserts outside RUN.
- Reset asserted mid-operation: immediate return to reset values, no chain_clear pulse.

Decomposition:
- Shared package (eggtimer_pkg):
  - state encoding constants IDLE/RUN/PAUSE/ALARM.
  - default TICK_DIV.
- Sub-module tick_prescaler:
  - inputs: clk, reset, run, clear.
  - output: wrap pulse.
  - parameters: TICK_DIV, DIV_WIDTH.
  - reusable for display refresh.
- Edge detection and FSM live in timer_control.

Test Plan:
All tests use TICK_DIV=4, ALARM_TICKS=3.
1. Reset with start_btn held high, then release and press once -> no start on the held level; after the press, state=RUN and count_en pulses every 4 cycles, each 1 cycle wide.
2. RUN, press stop at prescaler=2 -> state=PAUSE, no count_en. Press start after 10 cycles -> next count_en exactly 2 cycles later (resume from held value).
3. RUN with all_zero=1 at a wrap -> no count_en; state=ALARM, alarm=1. After 3 further wraps -> state=IDLE, alarm=0, single chain_clear pulse.
4. ALARM, press start -> IDLE next cycle, one chain_clear pulse, count_en stays 0.
5. PAUSE, start and stop pressed in the same cycle -> state=IDLE, chain_clear pulse; RUN not entered.
6. Assert reset during RUN at prescaler=3 -> all outputs 0, state=IDLE, no chain_clear; after release, a start press restarts the prescaler from 0.

Source files
------------

// File: rtl/eggtimer_pkg.sv
// Shared definitions for the egg timer: FSM state encoding and default tick rate.
package eggtimer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int unsigned TICK_DIV_DEFAULT  = 1000000;
  localparam int unsigned DIV_WIDTH_DEFAULT = 20;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts while run is high, pulses wrap on the last count.
module tick_prescaler
  import eggtimer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic wrap
);
  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(TICK_DIV - 1);

  logic [DIV_WIDTH-1:0] cnt;

  // wrap is qualified by run so a held counter sitting at LAST does not tick
  assign wrap = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/timer_control.sv
// Egg timer control: button edge detect, run/pause/alarm sequencing, 1 s count
// enable and the glitch-free digit-chain clear pulse.
module timer_control
  import eggtimer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       all_zero,
  output logic       count_en,
  output logic       chain_clear,
  output logic       alarm,
  output logic [1:0] state
);
  localparam int unsigned AW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t        state_q, state_nxt;
  logic          start_q, stop_q;
  logic          start_press, stop_press;
  logic          run, clear, wrap;
  logic [AW-1:0] acnt;

  assign start_press = start_btn & ~start_q;
  assign stop_press  = stop_btn & ~stop_q;

  // Any press that leaves the state also freezes the prescaler that cycle,
  // so a stop coinciding with a wrap holds the count at its last value.
  assign run = ((state_q == RUN) && !stop_press) ||
               ((state_q == ALARM) && !stop_press && !start_press);
  assign clear = (state_nxt == IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clear(clear),
    .wrap (wrap)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start_press && !stop_press) state_nxt = RUN;
      RUN: begin
        if (stop_press)            state_nxt = PAUSE;
        else if (wrap && all_zero) state_nxt = ALARM;
      end
      PAUSE: begin
        if (stop_press)       state_nxt = IDLE;
        else if (start_press) state_nxt = RUN;
      end
      ALARM: begin
        if (stop_press || start_press)       state_nxt = IDLE;
        else if (wrap && acnt == ALARM_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b1;
      stop_q      <= 1'b1;
      acnt        <= '0;
      count_en    <= 1'b0;
      chain_clear <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      start_q     <= start_btn;
      stop_q      <= stop_btn;
      count_en    <= (state_q == RUN) && wrap && !all_zero;
      chain_clear <= (state_q != IDLE) && (state_nxt == IDLE);
      alarm       <= (state_nxt == ALARM);
      if (state_q == ALARM && state_nxt == ALARM) begin
        if (wrap) acnt <= acnt + 1'b1;
      end else begin
        acnt <= '0;
      end
    end
  end

  assign state = state_q;
endmodule

// File: tb/tb_timer_control.sv
// Scoreboarded bench for timer_control with TICK_DIV=4, ALARM_TICKS=3.
module tb_timer_control;
  localparam int TD = 4;
  localparam int AT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b1;
  logic       stop_btn = 1'b0;
  logic       all_zero = 1'b0;
  logic       count_en, chain_clear, alarm;
  logic [1:0] state;

  timer_control #(.TICK_DIV(TD), .DIV_WIDTH(3), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .all_zero(all_zero), .count_en(count_en), .chain_clear(chain_clear),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       ce, cc, al;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: mode 0=idle 1=run 2=pause 3=alarm; phase = seconds fraction
  int m_mode = 0, m_phase = 0, m_left = 0;
  bit m_ps = 1, m_pt = 1;

  task automatic model(input bit s, input bit t, input bit a, input bit r, output exp_t e);
    bit sp, tp, last, ce;
    int old;
    e.cyc = cyc + 1;
    if (r) begin
      m_mode = 0; m_phase = 0; m_left = 0; m_ps = 1; m_pt = 1;
      e.ce = 0; e.cc = 0; e.al = 0; e.st = 2'd0;
      return;
    end
    sp = s && !m_ps; tp = t && !m_pt;
    m_ps = s; m_pt = t;
    old = m_mode; ce = 0;
    last = (m_phase == TD - 1);
    case (m_mode)
      0: if (sp && !tp) m_mode = 1;
      1: if (tp) m_mode = 2;
         else if (last) begin
           m_phase = 0;
           if (a) begin m_mode = 3; m_left = AT; end
           else ce = 1;
         end else m_phase++;
      2: if (tp) m_mode = 0; else if (sp) m_mode = 1;
      default: if (sp || tp) m_mode = 0;
         else if (last) begin
           m_phase = 0; m_left--;
           if (m_left == 0) m_mode = 0;
         end else m_phase++;
    endcase
    if (m_mode == 0) m_phase = 0;
    e.ce = ce;
    e.cc = (old != 0) && (m_mode == 0);
    e.al = (m_mode == 3);
    e.st = 2'(m_mode);
  endtask

  task automatic step(input bit s, input bit t, input bit a, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    start_btn = s; stop_btn = t; all_zero = a;
    model(s, t, a, r, e);
    q.push_back(e);
    if (r && !reset) begin
      #6;
      reset = 1'b1;
      #1;
      checks++;
      if ({count_en, chain_clear, alarm, state} !== 5'b0) begin
        errors++;
        $display("FAIL async_reset ce/cc/al/st got %b/%b/%b/%0d want 0/0/0/0",
                 count_en, chain_clear, alarm, state);
      end
    end else if (!r) begin
      reset = 1'b0;
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 8 && m_phase != p; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_until_alarm();
    for (int i = 0; i < 8 && m_mode != 3; i++) step(0, 0, 1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (count_en !== e.ce || chain_clear !== e.cc || alarm !== e.al || state !== e.st) begin
          errors++;
          $display("FAIL cycle%0d ce/cc/al/st got %b/%b/%b/%0d want %b/%b/%b/%0d",
                   e.cyc, count_en, chain_clear, alarm, state, e.ce, e.cc, e.al, e.st);
        end
      end
    end
  end

  initial begin : stimulus
    // Start held through reset and after release: must not start
    repeat (3) step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    // Pause at phase 2, resume later from the held phase
    wait_phase(2);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Reach zero: alarm runs three ticks then returns to idle
    run_until_alarm();
    repeat (16) step(0, 0, 0, 0);
    // Alarm acknowledged by start
    step(1, 0, 0, 0);
    run_until_alarm();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Pause then simultaneous start+stop
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Stop coinciding with a wrap
    step(1, 0, 0, 0);
    wait_phase(TD - 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Reset mid-run at phase 3, then restart
    wait_phase(3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 599) == 0);
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
